// File: rtl/pong_input_pkg.sv
// Purpose: shared keycode constants, paddle direction type and keycode decoder.
// Latency: decode_key is purely combinational.
// Backpressure: none, this package holds no state.
// Contents: KEY_* localparams, dir_t, key_hit_t, decode_key().
package pong_input_pkg;

  // Player 0 keys: W / S / A / D
  localparam logic [7:0] KEY_P0_UP    = 8'h1A;
  localparam logic [7:0] KEY_P0_DOWN  = 8'h16;
  localparam logic [7:0] KEY_P0_LEFT  = 8'h04;
  localparam logic [7:0] KEY_P0_RIGHT = 8'h07;
  // Player 1 keys: arrow cluster
  localparam logic [7:0] KEY_P1_UP    = 8'h52;
  localparam logic [7:0] KEY_P1_DOWN  = 8'h51;
  localparam logic [7:0] KEY_P1_LEFT  = 8'h50;
  localparam logic [7:0] KEY_P1_RIGHT = 8'h4F;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef struct packed {
    logic hit;
    logic player;
    dir_t dir;
  } key_hit_t;

  function automatic key_hit_t decode_key(input logic [7:0] key);
    key_hit_t res;
    res.hit    = 1'b1;
    res.player = 1'b0;
    res.dir    = DIR_UP;
    case (key)
      KEY_P0_UP:    begin res.player = 1'b0; res.dir = DIR_UP;    end
      KEY_P0_DOWN:  begin res.player = 1'b0; res.dir = DIR_DOWN;  end
      KEY_P0_LEFT:  begin res.player = 1'b0; res.dir = DIR_LEFT;  end
      KEY_P0_RIGHT: begin res.player = 1'b0; res.dir = DIR_RIGHT; end
      KEY_P1_UP:    begin res.player = 1'b1; res.dir = DIR_UP;    end
      KEY_P1_DOWN:  begin res.player = 1'b1; res.dir = DIR_DOWN;  end
      KEY_P1_LEFT:  begin res.player = 1'b1; res.dir = DIR_LEFT;  end
      KEY_P1_RIGHT: begin res.player = 1'b1; res.dir = DIR_RIGHT; end
      default:      res.hit = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/key_repeat_timer.sv
// Purpose: per-player press/hold/release tracker with auto-repeat and a one-deep request flag.
// Latency: request flag set on the same edge that samples a press or a repeat expiry.
// Backpressure: requests coalesce into o_req (newest dir wins) until the arbiter pulses i_clr.
// Ports: Clk, Reset; i_hit/i_dir this player's decoded key; i_clr arbiter grant; o_req/o_dir pending request.
module key_repeat_timer
  import pong_input_pkg::*;
#(
  parameter int unsigned REPEAT_CYCLES = 833333
) (
  input  logic Clk,
  input  logic Reset,
  input  logic i_hit,
  input  dir_t i_dir,
  input  logic i_clr,
  output logic o_req,
  output dir_t o_dir
);

  localparam int unsigned CW = $clog2(REPEAT_CYCLES);
  localparam logic [CW-1:0] RELOAD = CW'(REPEAT_CYCLES - 1);

  logic          r_hit_vld;
  dir_t          r_hit_dir;
  logic [CW-1:0] r_cnt;
  logic          r_req;
  dir_t          r_dir;

  logic w_press;
  logic w_fire;
  logic w_set;

  // A press is a new hit or a direction change for this player.
  assign w_press = i_hit && (!r_hit_vld || (r_hit_dir != i_dir));
  assign w_fire  = i_hit && !w_press && (r_cnt == '0);
  assign w_set   = w_press || w_fire;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_hit_vld <= 1'b0;
      r_hit_dir <= DIR_UP;
      r_cnt     <= '0;
      r_req     <= 1'b0;
      r_dir     <= DIR_UP;
    end else begin
      r_hit_vld <= i_hit;
      r_hit_dir <= i_dir;

      if (w_set)
        r_cnt <= RELOAD;
      else if (i_hit)
        r_cnt <= r_cnt - CW'(1);
      else
        r_cnt <= '0;

      // Set beats a same-edge clear so a fresh request is never dropped.
      if (w_set) begin
        r_req <= 1'b1;
        r_dir <= i_dir;
      end else if (i_clr) begin
        r_req <= 1'b0;
      end
    end
  end

  assign o_req = r_req;
  assign o_dir = r_dir;

endmodule

// File: rtl/paddle_cmd_scheduler.sv
// Purpose: turns the SoC HID keycode into paddle-move commands for two players on one valid/ready port.
// Latency: keycode sampled at edge N gives cmd_valid after edge N+1; at most one command per 2 cycles.
// Backpressure: cmd_* held stable while cmd_ready=0; further requests coalesce per player.
// Ports: Clk, Reset, keycode in; cmd_valid/cmd_player/cmd_dir out, cmd_ready in; pending per-player flags out.
module paddle_cmd_scheduler
  import pong_input_pkg::*;
#(
  parameter int unsigned REPEAT_CYCLES = 833333
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  output logic       cmd_valid,
  output logic       cmd_player,
  output logic [1:0] cmd_dir,
  input  logic       cmd_ready,
  output logic [1:0] pending
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } arb_state_t;

  key_hit_t   w_key;
  logic [1:0] w_hit;
  logic [1:0] w_req;
  logic [1:0] w_clr;
  dir_t       w_dir_p0;
  dir_t       w_dir_p1;
  logic       w_any;
  logic       w_pick;
  dir_t       w_pick_dir;

  arb_state_t r_state;
  logic       r_rr;
  logic       r_cmd_valid;
  logic       r_cmd_player;
  dir_t       r_cmd_dir;

  assign w_key    = decode_key(keycode);
  assign w_hit[0] = w_key.hit && (w_key.player == 1'b0);
  assign w_hit[1] = w_key.hit && (w_key.player == 1'b1);

  key_repeat_timer #(.REPEAT_CYCLES(REPEAT_CYCLES)) u_timer_p0 (
    .Clk   (Clk),
    .Reset (Reset),
    .i_hit (w_hit[0]),
    .i_dir (w_key.dir),
    .i_clr (w_clr[0]),
    .o_req (w_req[0]),
    .o_dir (w_dir_p0)
  );

  key_repeat_timer #(.REPEAT_CYCLES(REPEAT_CYCLES)) u_timer_p1 (
    .Clk   (Clk),
    .Reset (Reset),
    .i_hit (w_hit[1]),
    .i_dir (w_key.dir),
    .i_clr (w_clr[1]),
    .o_req (w_req[1]),
    .o_dir (w_dir_p1)
  );

  // Round-robin: the rr player goes first if it is asking, else the other one.
  assign w_any      = |w_req;
  assign w_pick     = w_req[r_rr] ? r_rr : ~r_rr;
  assign w_pick_dir = w_pick ? w_dir_p1 : w_dir_p0;
  assign w_clr[0]   = (r_state == ST_IDLE) && w_any && (w_pick == 1'b0);
  assign w_clr[1]   = (r_state == ST_IDLE) && w_any && (w_pick == 1'b1);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state      <= ST_IDLE;
      r_rr         <= 1'b0;
      r_cmd_valid  <= 1'b0;
      r_cmd_player <= 1'b0;
      r_cmd_dir    <= DIR_UP;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_cmd_valid  <= 1'b1;
            r_cmd_player <= w_pick;
            r_cmd_dir    <= w_pick_dir;
            r_state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (cmd_ready) begin
            r_cmd_valid <= 1'b0;
            r_rr        <= ~r_cmd_player;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_valid  = r_cmd_valid;
  assign cmd_player = r_cmd_player;
  assign cmd_dir    = r_cmd_dir;
  assign pending    = w_req;

endmodule

// File: tb/tb_paddle_cmd_scheduler.sv
// Directed bench for paddle_cmd_scheduler with REPEAT_CYCLES=4.
module tb_paddle_cmd_scheduler;
  import pong_input_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [7:0] keycode;
  logic       cmd_valid;
  logic       cmd_player;
  logic [1:0] cmd_dir;
  logic       cmd_ready;
  logic [1:0] pending;

  int n_chk  = 0;
  int n_pass = 0;

  // Accepted commands as {player, dir}.
  logic [2:0] acc_q[$];

  paddle_cmd_scheduler #(.REPEAT_CYCLES(4)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .keycode    (keycode),
    .cmd_valid  (cmd_valid),
    .cmd_player (cmd_player),
    .cmd_dir    (cmd_dir),
    .cmd_ready  (cmd_ready),
    .pending    (pending)
  );

  always #5 Clk = ~Clk;

  // Handshake state is stable at the falling edge ahead of the accepting rising edge.
  always @(negedge Clk) begin
    if (!Reset && cmd_valid && cmd_ready)
      acc_q.push_back({cmd_player, cmd_dir});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Drive inputs, then stop 1 time unit after the edge that samples them.
  task automatic tick(input logic [7:0] k, input logic r);
    keycode   = k;
    cmd_ready = r;
    @(posedge Clk);
    #1;
  endtask

  task automatic check_log(input string tag, input int exp_n, input logic [2:0] e0, input logic [2:0] e1);
    check({tag, "_count"}, acc_q.size(), exp_n);
    if (acc_q.size() > 0) check({tag, "_cmd0"}, acc_q[0], e0);
    if (acc_q.size() > 1 && exp_n > 1) check({tag, "_cmd1"}, acc_q[1], e1);
  endtask

  initial begin
    Reset     = 1'b1;
    keycode   = 8'h00;
    cmd_ready = 1'b0;
    #2;
    check("rst_valid",   cmd_valid,  0);
    check("rst_player",  cmd_player, 0);
    check("rst_dir",     cmd_dir,    0);
    check("rst_pending", pending,    0);
    @(negedge Clk);
    Reset = 1'b0;
    tick(8'h00, 1'b1);

    // Reset asserted while a command is stalled and player 1 is pending.
    tick(8'h04, 1'b0);
    tick(8'h50, 1'b0);
    check("midrst_pre_valid",   cmd_valid, 1);
    check("midrst_pre_pending", pending,   2'b10);
    Reset = 1'b1;
    #2;
    check("midrst_valid",   cmd_valid,  0);
    check("midrst_player",  cmd_player, 0);
    check("midrst_dir",     cmd_dir,    0);
    check("midrst_pending", pending,    0);
    #1;
    Reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(8'h00, 1'b1);
      check($sformatf("postrst_valid_%0d", i), cmd_valid, 0);
    end
    check("postrst_pending", pending, 0);

    // Single press of 0x1A for one cycle.
    acc_q.delete();
    tick(8'h1A, 1'b1);
    check("single_e0_valid", cmd_valid, 0);
    tick(8'h00, 1'b1);
    check("single_e1_valid",  cmd_valid,  1);
    check("single_e1_player", cmd_player, 0);
    check("single_e1_dir",    cmd_dir,    DIR_UP);
    tick(8'h00, 1'b1);
    check("single_e2_valid", cmd_valid, 0);
    for (int i = 0; i < 4; i++) tick(8'h00, 1'b1);
    check_log("single", 1, 3'b000, 3'b000);

    // Auto-repeat: 0x52 held over edges 0..19.
    acc_q.delete();
    for (int e = 0; e < 20; e++) begin
      tick(8'h52, 1'b1);
      check($sformatf("rep_valid_e%0d", e), cmd_valid, (e % 4 == 1) ? 1 : 0);
    end
    for (int i = 0; i < 4; i++) tick(8'h00, 1'b1);
    check("rep_count", acc_q.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < acc_q.size()) check($sformatf("rep_cmd%0d", i), acc_q[i], 3'b100);

    // Backpressure with both players requesting.
    acc_q.delete();
    tick(8'h04, 1'b0);
    tick(8'h4F, 1'b0);
    check("bp_e1_valid",   cmd_valid,  1);
    check("bp_e1_player",  cmd_player, 0);
    check("bp_e1_dir",     cmd_dir,    DIR_LEFT);
    check("bp_e1_pending", pending,    2'b10);
    for (int i = 0; i < 3; i++) begin
      tick(8'h00, 1'b0);
      check($sformatf("bp_hold_valid_%0d", i),  cmd_valid,  1);
      check($sformatf("bp_hold_player_%0d", i), cmd_player, 0);
      check($sformatf("bp_hold_dir_%0d", i),    cmd_dir,    DIR_LEFT);
      check($sformatf("bp_hold_pend_%0d", i),   pending,    2'b10);
    end
    tick(8'h00, 1'b1);
    check("bp_acc0_valid", cmd_valid, 0);
    tick(8'h00, 1'b1);
    check("bp_p1_valid",   cmd_valid,  1);
    check("bp_p1_player",  cmd_player, 1);
    check("bp_p1_dir",     cmd_dir,    DIR_RIGHT);
    check("bp_p1_pending", pending,    2'b00);
    for (int i = 0; i < 3; i++) tick(8'h00, 1'b1);
    check_log("bp", 2, 3'b010, 3'b111);

    // Coalescing: 0x16 held 10 cycles while stalled.
    acc_q.delete();
    for (int e = 0; e < 10; e++) tick(8'h16, 1'b0);
    check("coal_valid",   cmd_valid, 1);
    check("coal_dir",     cmd_dir,   DIR_DOWN);
    check("coal_pending", pending,   2'b01);
    tick(8'h00, 1'b0);
    check("coal_rel_pending", pending, 2'b01);
    tick(8'h00, 1'b1);
    check("coal_acc0_valid", cmd_valid, 0);
    tick(8'h00, 1'b1);
    check("coal_second_valid",   cmd_valid, 1);
    check("coal_second_dir",     cmd_dir,   DIR_DOWN);
    check("coal_second_pending", pending,   2'b00);
    for (int i = 0; i < 4; i++) tick(8'h00, 1'b1);
    check_log("coal", 2, 3'b001, 3'b001);

    // Direction change restarts the timer; 0x2C is unmapped.
    acc_q.delete();
    tick(8'h1A, 1'b1);
    tick(8'h1A, 1'b1);
    check("dir_e1_valid", cmd_valid, 1);
    check("dir_e1_dir",   cmd_dir,   DIR_UP);
    tick(8'h16, 1'b1);
    check("dir_e2_valid", cmd_valid, 0);
    tick(8'h2C, 1'b1);
    check("dir_e3_valid", cmd_valid, 1);
    check("dir_e3_dir",   cmd_dir,   DIR_DOWN);
    for (int i = 0; i < 8; i++) begin
      tick(8'h2C, 1'b1);
      if (i > 0) check($sformatf("unmapped_valid_%0d", i), cmd_valid, 0);
    end
    check("unmapped_pending", pending, 0);
    check_log("dir", 2, 3'b000, 3'b001);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/paddle_cmd_scheduler.md
# paddle_cmd_scheduler

Converts the raw USB HID keycode exported by the SoC into discrete paddle-move commands for the two Pong players. It tracks key presses and auto-repeat, keeps one pending request per player, and round-robin arbitrates both players onto a single valid/ready command port. The port feeds the paddle-position logic. The block sits between the SoC `keycode` output and the game-state datapath.

## Interface
- `REPEAT_CYCLES`, default 833333: cycles between auto-repeat moves while a key is held (60 Hz at 50 MHz); legal range ≥ 2.
- `Clk`  in  1  system clock; same domain as the SoC keycode output.
- `Reset`  in  1  asynchronous, active-high reset.
- `keycode`  in  8  current HID keycode; 0x00 means no key.
- `cmd_valid`  out  1  a command is presented.
- `cmd_player`  out  1  0 = player 0, 1 = player 1.
- `cmd_dir`  out  2  `dir_t` encoding: 0 UP, 1 DOWN, 2 LEFT, 3 RIGHT.
- `cmd_ready`  in  1  consumer accepts the command.
- `pending`  out  2  per-player pending request flags, for LEDs and debug.

## Operation
- Keycode decode, combinational:
  - Player 0: 0x1A→UP, 0x16→DOWN, 0x04→LEFT, 0x07→RIGHT.
  - Player 1: 0x52→UP, 0x51→DOWN, 0x50→LEFT, 0x4F→RIGHT.
  - Any other value is no-hit.
- Per-player tracker. It holds a registered copy of the last decoded hit (valid, dir) and a repeat counter.
  - **Press.** This player's hit differs from the last registered hit (new key, or same player with a new dir). Set `req[p]`, latch `dir[p]`, load counter with REPEAT_CYCLES−1.
  - **Hold.** The same hit repeats. If counter == 0, set `req[p]` and reload; otherwise decrement.
  - **Release.** This player has no hit. Clear the counter. An already-set `req[p]` is kept, so one move is still delivered.
  - **Coalescing.** If `req[p]` is already set when a new request arrives, requests merge (no queue). `dir[p]` takes the newest dir.
- Arbiter FSM:
  - **IDLE.** If any `req` is set, pick the player: the `rr` pointer player if its req is set, otherwise the other player. Load `cmd_player`/`cmd_dir`, set `cmd_valid`, clear that `req`, go to ISSUE.
  - **ISSUE.** Outputs held stable while `cmd_ready` = 0. On `cmd_valid & cmd_ready`: clear `cmd_valid`, set `rr` ← ~`cmd_player`, go to IDLE.
- A set and a clear of the same `req` on the same edge: set wins.
- Only one keycode exists at a time, but both players can still hold pending requests (key switched while stalled).

## Timing
- All registers reset asynchronously to 0:
  - `cmd_valid`, `cmd_player`, `cmd_dir`, `pending`;
  - `rr` (player 0 first), counters, registered hits;
  - FSM reset state is IDLE.
- Latency: a keycode sampled at edge 0 sets `req` at edge 0. `cmd_valid` is high after edge 1.
- Maximum throughput: one command per 2 cycles, because ISSUE→IDLE→ISSUE.
- While held, repeat requests fire every REPEAT_CYCLES edges, at edges 0, R, 2R, …
- `Reset` asserted in ISSUE drops `cmd_valid` immediately. Pending requests are lost.
- `cmd_ready` is ignored when `cmd_valid` = 0.

## Structure
- Package `pong_input_pkg` contains:
  - the eight keycode localparams;
  - `dir_t` enum;
  - a `decode_key` function returning hit/player/dir.
- Sub-module `key_repeat_timer`, instantiated twice (one per player). It holds the press/hold/release logic, the counter and the `req` flag, and takes a `clr` input from the arbiter.
- The arbiter FSM lives in the top module.

## Test plan
All scenarios use REPEAT_CYCLES=4.
1. **Reset.** Assert `Reset` mid-run → all outputs 0 asynchronously; after release with keycode 0x00, `cmd_valid` stays 0.
2. **Single press.** Keycode 0x1A for 1 cycle, `cmd_ready`=1 → exactly one command {player 0, UP}, `cmd_valid` high after edge 1.
3. **Auto-repeat.** Hold 0x52 over edges 0–19, `cmd_ready`=1 → 5 commands {player 1, UP}, valid after edges 1, 5, 9, 13, 17.
4. **Backpressure.**
   - `cmd_ready`=0; press 0x04, then 0x4F.
   - `cmd_valid` stays {0, LEFT} stable; `pending`=2'b10.
   - Raise `cmd_ready` → {0, LEFT} accepted, then {1, RIGHT}.
5. **Coalescing.** `cmd_ready`=0; hold 0x16 for 10 cycles, release, then raise `cmd_ready` → exactly 2 DOWN commands for player 0.
6. **Direction change and unmapped keys.** 0x1A held 2 cycles, then 0x16 → immediate second command DOWN (timer restarted). Keycode 0x2C → no command.
